// File: rtl/sram_axi_slave.sv
// AXI slave front-end for a single-port 32-bit synchronous SRAM.
// One transaction in flight; writes take one cycle per beat, reads two cycles per beat.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module sram_axi_slave #(
  parameter int MEM_ADDR_BITS = 14
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  // AW channel
  input  logic [`AXI_IDS_BITS-1:0]    AWID,
  input  logic [`AXI_ADDR_BITS-1:0]   AWADDR,
  input  logic [`AXI_LEN_BITS-1:0]    AWLEN,
  input  logic [`AXI_SIZE_BITS-1:0]   AWSIZE,
  input  logic [1:0]                  AWBURST,
  input  logic                        AWVALID,
  output logic                        AWREADY,
  // W channel
  input  logic [`AXI_DATA_BITS-1:0]   WDATA,
  input  logic [`AXI_STRB_BITS-1:0]   WSTRB,
  input  logic                        WLAST,
  input  logic                        WVALID,
  output logic                        WREADY,
  // B channel
  output logic [`AXI_IDS_BITS-1:0]    BID,
  output logic [1:0]                  BRESP,
  output logic                        BVALID,
  input  logic                        BREADY,
  // AR channel
  input  logic [`AXI_IDS_BITS-1:0]    ARID,
  input  logic [`AXI_ADDR_BITS-1:0]   ARADDR,
  input  logic [`AXI_LEN_BITS-1:0]    ARLEN,
  input  logic [`AXI_SIZE_BITS-1:0]   ARSIZE,
  input  logic [1:0]                  ARBURST,
  input  logic                        ARVALID,
  output logic                        ARREADY,
  // R channel
  output logic [`AXI_IDS_BITS-1:0]    RID,
  output logic [`AXI_DATA_BITS-1:0]   RDATA,
  output logic [1:0]                  RRESP,
  output logic                        RLAST,
  output logic                        RVALID,
  input  logic                        RREADY,
  // SRAM port
  output logic                        SRAM_CEB,
  output logic                        SRAM_WEB,
  output logic [31:0]                 SRAM_BWEB,
  output logic [MEM_ADDR_BITS-1:0]    SRAM_A,
  output logic [31:0]                 SRAM_DI,
  input  logic [31:0]                 SRAM_DO
);

  typedef enum logic [2:0] {
    IDLE,
    W_DATA,
    W_RESP,
    R_ACCESS,
    R_DATA
  } state_t;

  state_t                     state_q, state_d;
  logic                       ready_q;
  logic [`AXI_IDS_BITS-1:0]   bid_q, rid_q;
  logic [MEM_ADDR_BITS-1:0]   addr_q;
  logic [`AXI_LEN_BITS-1:0]   len_q, beat_q;
  logic                       aw_hs, w_hs, ar_hs, r_hs;

  // Size, burst type and byte offset are deliberately ignored: every burst is INCR of words.
  logic unused_in;
  assign unused_in = ^{AWSIZE, AWBURST, ARSIZE, ARBURST, AWADDR, ARADDR};

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      bid_q   <= '0;
      rid_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
      if (aw_hs) begin
        bid_q  <= AWID;
        addr_q <= AWADDR[MEM_ADDR_BITS+1:2];
        len_q  <= AWLEN;
      end else if (ar_hs) begin
        rid_q  <= ARID;
        addr_q <= ARADDR[MEM_ADDR_BITS+1:2];
        len_q  <= ARLEN;
        beat_q <= '0;
      end else if (w_hs || (r_hs && !RLAST)) begin
        addr_q <= addr_q + MEM_ADDR_BITS'(1);
      end
      if (r_hs && !RLAST) begin
        beat_q <= beat_q + `AXI_LEN_BITS'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    AWREADY   = 1'b0;
    WREADY    = 1'b0;
    BVALID    = 1'b0;
    ARREADY   = 1'b0;
    RVALID    = 1'b0;
    RLAST     = 1'b0;
    RDATA     = '0;
    SRAM_CEB  = 1'b1;
    SRAM_WEB  = 1'b1;
    SRAM_BWEB = '1;
    SRAM_A    = '0;
    SRAM_DI   = '0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    ar_hs     = 1'b0;
    r_hs      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // ready_q holds the ready lines low until the first edge after reset release
        AWREADY = ready_q;
        ARREADY = ready_q && !AWVALID;
        aw_hs   = AWVALID && ready_q;
        ar_hs   = ARVALID && ready_q && !AWVALID;
        if (aw_hs) begin
          state_d = W_DATA;
        end else if (ar_hs) begin
          state_d = R_ACCESS;
        end
      end
      W_DATA: begin
        WREADY = 1'b1;
        w_hs   = WVALID;
        if (w_hs) begin
          SRAM_CEB = 1'b0;
          SRAM_WEB = 1'b0;
          SRAM_A   = addr_q;
          SRAM_DI  = WDATA;
          for (int unsigned i = 0; i < 4; i++) begin
            SRAM_BWEB[i*8 +: 8] = WSTRB[i] ? 8'h00 : 8'hFF;
          end
          if (WLAST) begin
            state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) begin
          state_d = IDLE;
        end
      end
      R_ACCESS: begin
        SRAM_CEB = 1'b0;
        SRAM_A   = addr_q;
        state_d  = R_DATA;
      end
      R_DATA: begin
        // SRAM stays deselected here, so SRAM_DO (and RDATA) hold through a stall
        RVALID = 1'b1;
        RDATA  = SRAM_DO;
        RLAST  = (beat_q == len_q);
        r_hs   = RREADY;
        if (r_hs) begin
          state_d = RLAST ? IDLE : R_ACCESS;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign BID   = bid_q;
  assign BRESP = 2'b00;
  assign RID   = rid_q;
  assign RRESP = 2'b00;

endmodule

// File: tb/tb_sram_axi_slave.sv
// Directed bench for sram_axi_slave with a behavioural SRAM attached.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module tb_sram_axi_slave;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [7:0]  AWID = '0;
  logic [31:0] AWADDR = '0;
  logic [3:0]  AWLEN = '0;
  logic [2:0]  AWSIZE = 3'd2;
  logic [1:0]  AWBURST = 2'b01;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WLAST = 1'b0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [7:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [7:0]  ARID = '0;
  logic [31:0] ARADDR = '0;
  logic [3:0]  ARLEN = '0;
  logic [2:0]  ARSIZE = 3'd2;
  logic [1:0]  ARBURST = 2'b01;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [7:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY = 1'b0;
  logic        SRAM_CEB;
  logic        SRAM_WEB;
  logic [31:0] SRAM_BWEB;
  logic [13:0] SRAM_A;
  logic [31:0] SRAM_DI;
  logic [31:0] SRAM_DO = '0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:16383];
  logic [31:0] wdata_q [$];
  logic [31:0] exp_q [$];

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) begin
    if (!SRAM_CEB) begin
      if (!SRAM_WEB) mem[SRAM_A] <= (mem[SRAM_A] & SRAM_BWEB) | (SRAM_DI & ~SRAM_BWEB);
      else           SRAM_DO <= mem[SRAM_A];
    end
  end

  sram_axi_slave #(.MEM_ADDR_BITS(14)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .SRAM_CEB(SRAM_CEB), .SRAM_WEB(SRAM_WEB), .SRAM_BWEB(SRAM_BWEB), .SRAM_A(SRAM_A),
    .SRAM_DI(SRAM_DI), .SRAM_DO(SRAM_DO)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write burst from wdata_q; every beat uses the same strobe and its hand-computed BWEB.
  task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] strb,
                          input logic [31:0] exp_bweb, input int bstall, input bit tie);
    logic [13:0] wa;
    int n;
    wa = addr[15:2];
    n  = wdata_q.size();
    @(negedge ACLK);
    AWID = id; AWADDR = addr; AWLEN = 4'(n - 1); AWVALID = 1'b1;
    ARVALID = tie; ARADDR = 32'h0000_0040; ARLEN = 4'd0;
    #1;
    check("aw_ready", AWREADY, 1);
    if (tie) check("tie_arready", ARREADY, 0);
    for (int i = 0; i < n; i++) begin
      @(negedge ACLK);
      AWVALID = 1'b0; ARVALID = 1'b0;
      WVALID = 1'b1; WDATA = wdata_q[i]; WSTRB = strb; WLAST = (i == n - 1);
      #1;
      check("w_ready", WREADY, 1);
      check("w_awready", AWREADY, 0);
      check("w_ceb", SRAM_CEB, 0);
      check("w_web", SRAM_WEB, 0);
      check("w_addr", SRAM_A, wa);
      check("w_bweb", SRAM_BWEB, exp_bweb);
      check("w_di", SRAM_DI, wdata_q[i]);
      wa = wa + 14'd1;
    end
    @(negedge ACLK);
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b0;
    #1;
    for (int k = 0; k <= bstall; k++) begin
      if (k > 0) begin
        @(negedge ACLK);
        #1;
      end
      check("b_valid", BVALID, 1);
      check("b_id", BID, id);
      check("b_resp", BRESP, 0);
      check("b_ceb", SRAM_CEB, 1);
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    #1;
    check("b_done_valid", BVALID, 0);
    check("b_done_awready", AWREADY, 1);
    wdata_q.delete();
  endtask

  // Read burst checked against exp_q; beat 0 is optionally stalled for `stall` cycles.
  task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input int stall);
    logic [13:0] wa;
    wa = addr[15:2];
    @(negedge ACLK);
    ARID = id; ARADDR = addr; ARLEN = len; ARVALID = 1'b1; RREADY = 1'b0;
    #1;
    check("ar_ready", ARREADY, 1);
    @(negedge ACLK);
    ARVALID = 1'b0;
    #1;
    for (int b = 0; b <= int'(len); b++) begin
      check("racc_valid", RVALID, 0);
      check("racc_ceb", SRAM_CEB, 0);
      check("racc_web", SRAM_WEB, 1);
      check("racc_addr", SRAM_A, wa);
      @(negedge ACLK);
      RREADY = !(b == 0 && stall > 0);
      #1;
      check("r_valid", RVALID, 1);
      check("r_data", RDATA, exp_q[b]);
      check("r_id", RID, id);
      check("r_resp", RRESP, 0);
      check("r_last", RLAST, b == int'(len));
      check("r_ceb", SRAM_CEB, 1);
      if (b == 0 && stall > 0) begin
        for (int k = 1; k < stall; k++) begin
          @(negedge ACLK);
          #1;
          check("rstall_valid", RVALID, 1);
          check("rstall_data", RDATA, exp_q[b]);
          check("rstall_ceb", SRAM_CEB, 1);
        end
        RREADY = 1'b1;
      end
      @(negedge ACLK);
      RREADY = 1'b0;
      #1;
      wa = wa + 14'd1;
    end
    check("r_done_valid", RVALID, 0);
    check("r_done_arready", ARREADY, 1);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge ACLK);
    #1;
    check("rst_awready", AWREADY, 0);
    check("rst_arready", ARREADY, 0);
    check("rst_bvalid", BVALID, 0);
    check("rst_rvalid", RVALID, 0);
    check("rst_ceb", SRAM_CEB, 1);
    check("rst_web", SRAM_WEB, 1);
    check("rst_bweb", SRAM_BWEB, 32'hFFFF_FFFF);
    check("rst_addr", SRAM_A, 0);
    check("rst_di", SRAM_DI, 0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    #1;
    check("rel_awready_pre", AWREADY, 0);
    @(negedge ACLK);
    #1;
    check("rel_awready", AWREADY, 1);
    check("rel_arready", ARREADY, 1);

    // single full write, B held for 3 cycles
    wdata_q.push_back(32'hDEAD_BEEF);
    do_write(8'h05, 32'h0000_0010, 4'hF, 32'h0000_0000, 3, 1'b0);

    // partial write over a known word, then read it back
    wdata_q.push_back(32'h1122_3344);
    do_write(8'h01, 32'h0000_0020, 4'hF, 32'h0000_0000, 0, 1'b0);
    wdata_q.push_back(32'hAABB_CCDD);
    do_write(8'h02, 32'h0000_0020, 4'b0101, 32'hFF00_FF00, 0, 1'b0);
    exp_q.push_back(32'h11BB_33DD);
    do_read(8'h03, 32'h0000_0020, 4'd0, 0);

    // 4-beat burst at word 0x40, read back with a 5-cycle stall on beat 1
    wdata_q.push_back(32'hA0A0_0000);
    wdata_q.push_back(32'hA1A1_1111);
    wdata_q.push_back(32'hA2A2_2222);
    wdata_q.push_back(32'hA3A3_3333);
    do_write(8'h04, 32'h0000_0100, 4'hF, 32'h0000_0000, 0, 1'b0);
    exp_q.push_back(32'hA0A0_0000);
    exp_q.push_back(32'hA1A1_1111);
    exp_q.push_back(32'hA2A2_2222);
    exp_q.push_back(32'hA3A3_3333);
    do_read(8'h06, 32'h0000_0100, 4'd3, 5);

    // AW/AR tie, write wraps from word 0x3FFF to 0, unaligned read wraps likewise
    wdata_q.push_back(32'h1234_5678);
    wdata_q.push_back(32'h9ABC_DEF0);
    do_write(8'h07, 32'h0000_FFFC, 4'hF, 32'h0000_0000, 0, 1'b1);
    exp_q.push_back(32'h1234_5678);
    exp_q.push_back(32'h9ABC_DEF0);
    do_read(8'h08, 32'h0000_FFFE, 4'd1, 0);

    // reset while a burst read is presenting beat 1
    @(negedge ACLK);
    ARID = 8'h0A; ARADDR = 32'h0000_0100; ARLEN = 4'd3; ARVALID = 1'b1; RREADY = 1'b0;
    #1;
    check("mrst_arready", ARREADY, 1);
    @(negedge ACLK);
    ARVALID = 1'b0;
    @(negedge ACLK);
    #1;
    check("mrst_rvalid_pre", RVALID, 1);
    ARESETn = 1'b0;
    #1;
    check("mrst_rvalid", RVALID, 0);
    check("mrst_rid", RID, 0);
    check("mrst_ceb", SRAM_CEB, 1);
    check("mrst_arready", ARREADY, 0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    #1;
    check("mrst_arready_pre", ARREADY, 0);
    @(negedge ACLK);
    #1;
    check("mrst_rvalid_post", RVALID, 0);
    check("mrst_arready_post", ARREADY, 1);
    exp_q.push_back(32'hDEAD_BEEF);
    do_read(8'h09, 32'h0000_0010, 4'd0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
